// File: rtl/softmax_batch_stream.sv
// Streaming softmax: LUT-based exp per element, row or multi-row batch sum, fixed-point normalise.
// Latency accept->out_valid 4 cycles in row mode; no batch overlap, in_ready low from batch close until DRAIN ends.
module softmax_batch_stream #(
    parameter int BW   = 8,
    parameter int COL  = 8,
    parameter int ROWS = 8,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [1:0]          lut_wr,
    input  logic [BW/2-1:0]     lut_addr,
    input  logic [BW-1:0]       lut_data,
    input  logic [COL*BW-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [COL*BW-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                err_ovf,
    output logic                busy
);
    localparam int HW = BW / 2;
    localparam int LD = 1 << HW;
    localparam int SW = BW + $clog2(COL * ROWS);
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(ROWS + 1);
    localparam int NW = BW + FRAC;
    localparam int DW = (NW > SW) ? NW : SW;
    localparam logic [BW-1:0] MAXV = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                mode_q;
    logic                closed;
    logic [CW-1:0]       acc_cnt;
    logic                s1_vld;
    logic [IW-1:0]       s1_idx;
    logic [COL*BW-1:0]   s1_e;
    logic [SW-1:0]       sum;
    logic                fl_cnt;
    logic [IW-1:0]       rd_idx;

    logic [BW-1:0]       lut_hi [LD];
    logic [BW-1:0]       lut_lo [LD];
    logic [COL*BW-1:0]   rowbuf [ROWS];

    logic [COL*BW-1:0]   e_row;
    logic [2*BW-1:0]     prod;
    logic [SW-1:0]       row_sum;
    logic [IW-1:0]       sel;
    logic [COL*BW-1:0]   src;
    logic [COL*BW-1:0]   norm_row;
    logic [DW-1:0]       num;
    logic [DW-1:0]       den;
    logic [DW-1:0]       quo;

    logic                accept;
    logic                close_now;
    logic                last_row;

    assign accept    = in_valid && in_ready;
    assign close_now = !mode_q || in_last || (acc_cnt == CW'(ROWS - 1));
    assign last_row  = (rd_idx == IW'(acc_cnt - 1'b1));

    // LUTs are deliberately outside reset so tables survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (lut_wr[1]) lut_hi[lut_addr] <= lut_data;
            if (lut_wr[0]) lut_lo[lut_addr] <= lut_data;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_vld) rowbuf[s1_idx] <= s1_e;
    end

    always_comb begin
        e_row = '0;
        prod  = '0;
        for (int i = 0; i < COL; i++) begin
            prod = (2*BW)'(lut_hi[in_data[i*BW+HW +: HW]]) * (2*BW)'(lut_lo[in_data[i*BW +: HW]]);
            e_row[i*BW +: BW] = prod[2*BW-1:BW];
        end
    end

    always_comb begin
        row_sum = '0;
        for (int i = 0; i < COL; i++) begin
            row_sum = row_sum + SW'(s1_e[i*BW +: BW]);
        end
    end

    // Next row is prepared one step ahead so out_data always comes straight from a register.
    always_comb begin
        sel      = (state == FLUSH) ? '0 : rd_idx + 1'b1;
        src      = rowbuf[sel];
        den      = (sum == '0) ? DW'(1) : DW'(sum);
        norm_row = '0;
        num      = '0;
        quo      = '0;
        for (int i = 0; i < COL; i++) begin
            num = DW'({src[i*BW +: BW], {FRAC{1'b0}}});
            quo = num / den;
            if (sum == '0 || quo > DW'(MAXV))
                norm_row[i*BW +: BW] = MAXV;
            else
                norm_row[i*BW +: BW] = quo[BW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid && lut_wr == 2'b00) state_nxt = ACCUM;
            ACCUM: if (closed) state_nxt = FLUSH;
            FLUSH: if (fl_cnt) state_nxt = DRAIN;
            DRAIN: if (out_ready && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM) && !closed && (acc_cnt < CW'(ROWS));
        busy      = (state != IDLE);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && last_row;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= 1'b0;
            closed   <= 1'b0;
            acc_cnt  <= '0;
            s1_vld   <= 1'b0;
            s1_idx   <= '0;
            s1_e     <= '0;
            sum      <= '0;
            fl_cnt   <= 1'b0;
            rd_idx   <= '0;
            out_data <= '0;
            err_ovf  <= 1'b0;
        end else begin
            err_ovf <= 1'b0;
            s1_vld  <= accept;
            case (state)
                IDLE: begin
                    if (in_valid && lut_wr == 2'b00) begin
                        mode_q  <= mode;
                        sum     <= '0;
                        acc_cnt <= '0;
                        closed  <= 1'b0;
                        fl_cnt  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        s1_e    <= e_row;
                        s1_idx  <= IW'(acc_cnt);
                        acc_cnt <= acc_cnt + 1'b1;
                        if (close_now) closed <= 1'b1;
                        if (mode_q && !in_last && acc_cnt == CW'(ROWS - 1)) err_ovf <= 1'b1;
                    end
                end
                FLUSH: begin
                    fl_cnt <= ~fl_cnt;
                    if (fl_cnt) begin
                        out_data <= norm_row;
                        rd_idx   <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready && !last_row) begin
                        rd_idx   <= rd_idx + 1'b1;
                        out_data <= norm_row;
                    end
                end
                default: ;
            endcase
            if (s1_vld) sum <= sum + row_sum;
        end
    end
endmodule

// File: tb/tb_softmax_batch_stream.sv
// Directed bench for softmax_batch_stream: row/batch modes, saturation, overflow close, stall, reset.
module tb_softmax_batch_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  lut_wr;
    logic [3:0]  lut_addr;
    logic [7:0]  lut_data;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] ROW32 = 64'h2020202020202020;
    localparam logic [63:0] ROW16 = 64'h1010101010101010;
    localparam logic [63:0] ROW04 = 64'h0404040404040404;
    localparam logic [63:0] ROWFF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] ROW12 = 64'h0C0C0C0C0C0C0C0C;
    localparam logic [63:0] ROW06 = 64'h0606060606060606;

    softmax_batch_stream dut (
        .clk(clk), .reset(reset), .mode(mode), .lut_wr(lut_wr), .lut_addr(lut_addr),
        .lut_data(lut_data), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err_ovf(err_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lut_fill(input logic [1:0] which, input logic [7:0] val);
        for (int a = 0; a < 16; a++) begin
            lut_wr = which; lut_addr = 4'(a); lut_data = val;
            step();
        end
        lut_wr = 2'b00;
    endtask

    task automatic lut_one(input logic [1:0] which, input logic [3:0] a, input logic [7:0] val);
        lut_wr = which; lut_addr = a; lut_data = val;
        step();
        lut_wr = 2'b00;
    endtask

    // Returns at the first sample point after the accepting edge.
    task automatic send_row(input string tag, input logic [63:0] d, input logic last);
        int n;
        in_data = d; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin
            step(); n++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic recv_row(input string tag, input logic [63:0] d, input logic last);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            step(); n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, 64'(out_last), 64'(last));
        step();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; lut_wr = 2'b00; lut_addr = '0; lut_data = '0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", out_data, 64'd0);

        // Row mode, all LUT entries 255: e=254, sum=2032 -> 32
        lut_fill(2'b11, 8'hFF);
        mode = 1'b0;
        send_row("t1", 64'h0123456789ABCDEF, 1'b0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready_after_close", 64'(in_ready), 64'd0);
        step(); step();
        chk("t1_lat3_novalid", 64'(out_valid), 64'd0);
        step();
        chk("t1_lat4_valid", 64'(out_valid), 64'd1);
        recv_row("t1_row", ROW32, 1'b1);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // Batch of two rows: sum=4064 -> 16, out_last only on row 2
        mode = 1'b1;
        send_row("t2a", 64'hFEDCBA9876543210, 1'b0);
        send_row("t2b", 64'h5A5A5A5A5A5A5A5A, 1'b1);
        recv_row("t2_row0", ROW16, 1'b0);
        recv_row("t2_row1", ROW16, 1'b1);

        // hi LUT all zero: sum=0 -> every element saturates
        mode = 1'b0;
        lut_fill(2'b10, 8'h00);
        send_row("t3a", 64'h0123456789ABCDEF, 1'b0);
        recv_row("t3a_row", ROWFF, 1'b0 | 1'b1);

        // One large element (e=254, sum=254 -> 256 -> 255), others e=0
        lut_one(2'b10, 4'hF, 8'hFF);
        send_row("t3b", 64'h00000A00F3000000, 1'b0);
        recv_row("t3b_row", 64'h00000000FF000000, 1'b1);
        lut_fill(2'b10, 8'hFF);

        // Nine rows without in_last: 8 taken, err_ovf pulse, sum=16256 -> 4
        mode = 1'b1;
        for (int r = 0; r < 8; r++) send_row("t4", 64'h1111111111111111 * 64'(r + 1), 1'b0);
        chk("t4_err_ovf_pulse", 64'(err_ovf), 64'd1);
        chk("t4_ready_low", 64'(in_ready), 64'd0);
        in_data = 64'h9999999999999999; in_last = 1'b0; in_valid = 1'b1;
        mode = 1'b0;
        step();
        chk("t4_err_ovf_once", 64'(err_ovf), 64'd0);
        chk("t4_pending_ready", 64'(in_ready), 64'd0);
        for (int r = 0; r < 8; r++) recv_row("t4_row", ROW04, (r == 7));
        send_row("t4_row9", 64'h9999999999999999, 1'b0);
        recv_row("t4_row9_out", ROW32, 1'b1);

        // Stall mid-DRAIN; rows differ (e=254,127,254; sum=5080 -> 12,6,12)
        lut_one(2'b01, 4'h2, 8'h80);
        mode = 1'b1;
        send_row("t5a", 64'h0101010101010101, 1'b0);
        mode = 1'b0;
        send_row("t5b", 64'h0202020202020202, 1'b0);
        send_row("t5c", 64'h0101010101010101, 1'b1);
        recv_row("t5_row0", ROW12, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_stall_valid", 64'(out_valid), 64'd1);
            chk("t5_stall_data", out_data, ROW06);
        end
        out_ready = 1'b1;
        recv_row("t5_row1", ROW06, 1'b0);
        recv_row("t5_row2", ROW12, 1'b1);
        chk("t5_done", 64'(out_valid), 64'd0);
        lut_one(2'b01, 4'h2, 8'hFF);

        // Reset while a row is held in DRAIN
        mode = 1'b0;
        out_ready = 1'b0;
        send_row("t6a", 64'h0123456789ABCDEF, 1'b0);
        step(); step(); step();
        chk("t6_in_drain", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_data", out_data, 64'd0);
        out_ready = 1'b1;

        // LUT survives reset; writes during ACCUM/FLUSH are ignored
        send_row("t6b", 64'h0000000000000000, 1'b0);
        lut_wr = 2'b11; lut_addr = 4'h0; lut_data = 8'h00;
        step(); step();
        lut_wr = 2'b00;
        recv_row("t6b_row", ROW32, 1'b1);
        send_row("t6c", 64'h0000000000000000, 1'b0);
        recv_row("t6c_row", ROW32, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
